// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: slave register map,
// CTRL bit positions, FSM state encoding and a small pattern helper.
package led_seq_pkg;

  // Slave register addresses
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_PATTERN = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_RUN_BIT     = 0;
  localparam int CTRL_MODE_BIT    = 1;
  localparam int CTRL_ONESHOT_BIT = 2;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Loadable tick prescaler: a down-counter that reloads on 'load', decrements
// while 'en' is high and holds at zero. 'tc' flags terminal count (zero).
//
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   load        - reload counter with load_val (has priority over en)
//   load_val    - reload value
//   en          - decrement enable
//   tc          - counter is zero
module led_seq_prescaler #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer. CPU loads up to DEPTH patterns and a tick period
// through the slave port, then sets run; on every tick the block writes the
// next pattern to the LED PIO data register through its master port.
//
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   address/chipselect/write_n/writedata/readdata - Avalon-MM slave
//   m_address/m_chipselect/m_write_n/m_writedata  - Avalon-MM master to PIO
//   done_irq            - level, set when a one-shot run completes
//
// state | meaning
// IDLE  | not sequencing; waits for run with something to play
// WRITE | single-cycle master write of the next pattern, prescaler reload
// COUNT | prescaler counting down to the next tick
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        done_irq
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

  logic [1:0]          state_q, state_d;
  logic                run_q, run_d;
  logic                mode_q, mode_d;
  logic                oneshot_q, oneshot_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [7:0]          table_q [DEPTH];
  logic [7:0]          table_d [DEPTH];
  logic [IDX_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          cur_q, cur_d;
  logic                done_q, done_d;
  logic                first_q, first_d;

  logic             wr_en, wr_ctrl, wr_period, wr_pattern, wr_status;
  logic             tc, busy, wrap;
  logic [LEN_W-1:0] idx_plus1;
  logic [7:0]       next_pat;
  logic             unused_wdata;

  assign wr_en      = chipselect && !write_n;
  assign wr_ctrl    = wr_en && (address == REG_CTRL);
  assign wr_period  = wr_en && (address == REG_PERIOD);
  assign wr_pattern = wr_en && (address == REG_PATTERN);
  assign wr_status  = wr_en && (address == REG_STATUS);

  assign unused_wdata = ^writedata[31:PERIOD_W];

  assign busy      = (state_q != ST_IDLE);
  assign idx_plus1 = {1'b0, idx_q} + 1'b1;
  assign wrap      = (idx_plus1 == len_q);

  // Rotate mode seeds from table[0] on the first write of a run, then
  // rotates whatever was last driven to the PIO.
  always_comb begin
    if (mode_q) begin
      next_pat = first_q ? table_q[0] : rotl8(cur_q);
    end else begin
      next_pat = table_q[idx_q];
    end
  end

  // Reloading during WRITE gives P+1 COUNT cycles, i.e. P+2 write spacing.
  led_seq_prescaler #(.W(PERIOD_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == ST_WRITE),
    .load_val (period_q),
    .en       (state_q == ST_COUNT),
    .tc       (tc)
  );

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    mode_d    = mode_q;
    oneshot_d = oneshot_q;
    period_d  = period_q;
    table_d   = table_q;
    wr_ptr_d  = wr_ptr_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    done_d    = done_q;
    first_d   = first_q;

    case (state_q)
      ST_IDLE: begin
        if (run_q && ((len_q != '0) || mode_q)) begin
          state_d = ST_WRITE;
          idx_d   = '0;
          first_d = 1'b1;
        end
      end
      ST_WRITE: begin
        cur_d   = next_pat;
        first_d = 1'b0;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (tc) begin
          if (mode_q) begin
            state_d = ST_WRITE;
          end else if (!wrap) begin
            idx_d   = idx_plus1[IDX_W-1:0];
            state_d = ST_WRITE;
          end else if (oneshot_q) begin
            idx_d   = '0;
            done_d  = 1'b1;
            run_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = '0;
            state_d = ST_WRITE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Slave writes are applied after the FSM so that clearing run or the
    // table overrides a COUNT->WRITE tick in the same cycle.
    if (wr_ctrl) begin
      run_d     = writedata[CTRL_RUN_BIT];
      mode_d    = writedata[CTRL_MODE_BIT];
      oneshot_d = writedata[CTRL_ONESHOT_BIT];
      if (!writedata[CTRL_RUN_BIT]) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    end

    if (wr_period) begin
      period_d = writedata[PERIOD_W-1:0];
    end

    if (wr_pattern && (len_q != LEN_FULL)) begin
      table_d[wr_ptr_q] = writedata[7:0];
      wr_ptr_d          = wr_ptr_q + 1'b1;
      len_d             = len_q + 1'b1;
    end

    if (wr_status) begin
      len_d    = '0;
      wr_ptr_d = '0;
      done_d   = 1'b0;
      run_d    = 1'b0;
      idx_d    = '0;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      mode_q    <= 1'b0;
      oneshot_q <= 1'b0;
      period_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      cur_q     <= '0;
      done_q    <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      mode_q    <= mode_d;
      oneshot_q <= oneshot_d;
      period_q  <= period_d;
      table_q   <= table_d;
      wr_ptr_q  <= wr_ptr_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      done_q    <= done_d;
      first_q   <= first_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL: begin
        readdata[CTRL_RUN_BIT]     = run_q;
        readdata[CTRL_MODE_BIT]    = mode_q;
        readdata[CTRL_ONESHOT_BIT] = oneshot_q;
      end
      REG_PERIOD:  readdata[PERIOD_W-1:0] = period_q;
      REG_PATTERN: readdata[7:0] = cur_q;
      REG_STATUS:  readdata = 32'({done_q, idx_q, (len_q == '0), busy});
      default:     readdata = '0;
    endcase
  end

  // Master outputs decode straight from the state flop, so an asynchronous
  // reset drops the write strobe in the same cycle.
  assign m_address    = 2'b00;
  assign m_chipselect = (state_q == ST_WRITE);
  assign m_write_n    = (state_q != ST_WRITE);
  assign m_writedata  = (state_q == ST_WRITE) ? {24'b0, next_pat} : 32'b0;
  assign done_irq     = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        done_irq;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  addr;
    logic [31:0] data;
  } mw_t;
  mw_t wq[$];

  typedef struct {
    string       name;
    bit          do_wr;
    bit          cs;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [9];

  led_pattern_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .done_irq     (done_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && m_chipselect && !m_write_n)
      wq.push_back('{cyc, m_address, m_writedata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input bit cs = 1'b1);
    @(negedge clk);
    address = a; chipselect = cs; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
  endtask

  task automatic wait_writes(input int n, input int bound, input string tag);
    int t = 0;
    while (wq.size() < n && t < bound) begin
      @(negedge clk); #1;
      t++;
    end
    check({tag, " writes_seen"}, 32'(wq.size() >= n), 32'd1);
  endtask

  // Reference: mode 0 replays the table in order; mode 1 starts at the
  // first table entry and rotates left by one each tick. Ticks are P+2 apart.
  task automatic run_seq(input logic [7:0] pats [4], input int n, input int p,
                         input bit mode, input bit oneshot, input int nwr, input string tag);
    logic [7:0]  expq[$];
    logic [7:0]  cur;
    logic [31:0] rd;
    int          n_exp;
    n_exp = (!mode && oneshot) ? n : nwr;
    cur = 8'h00;
    for (int k = 0; k < n_exp; k++) begin
      if (mode) cur = (k == 0) ? pats[0] : 8'(((int'(cur) << 1) | (int'(cur) >> 7)) & 8'hFF);
      else      cur = pats[k % n];
      expq.push_back(cur);
    end

    bus_write(REG_CTRL, 32'h0);
    bus_write(REG_STATUS, 32'h0);
    for (int i = 0; i < n; i++) bus_write(REG_PATTERN, {24'h0, pats[i]});
    bus_write(REG_PERIOD, 32'(p));
    wq.delete();
    bus_write(REG_CTRL, {29'b0, oneshot, mode, 1'b1});
    wait_writes(n_exp, n_exp * (p + 2) + 20, tag);

    if (!mode && oneshot) begin
      idle(p + 6);
      check({tag, " oneshot_count"}, 32'(wq.size()), 32'(n_exp));
      check({tag, " done_irq"}, 32'(done_irq), 32'd1);
      reg_read(REG_STATUS, rd);
      check({tag, " status_done"}, rd, 32'h10);
    end else begin
      bus_write(REG_CTRL, 32'h0);
    end

    for (int k = 0; k < n_exp; k++) begin
      if (k < wq.size()) begin
        check($sformatf("%s data[%0d]", tag, k), wq[k].data, {24'h0, expq[k]});
        check($sformatf("%s addr[%0d]", tag, k), 32'(wq[k].addr), 32'd0);
        if (k > 0)
          check($sformatf("%s spacing[%0d]", tag, k), wq[k].cyc - wq[k-1].cyc, 32'(p + 2));
      end
    end
    idle(p + 6);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  pa [4];
    int          t;

    vecs[0] = '{"ctrl_rw",        1, 1, REG_CTRL,    32'h6,        REG_CTRL,    32'h6};
    vecs[1] = '{"period_trunc",   1, 1, REG_PERIOD,  32'hFFFFFFFF, REG_PERIOD,  32'h00FFFFFF};
    vecs[2] = '{"period_rw",      1, 1, REG_PERIOD,  32'h12,       REG_PERIOD,  32'h12};
    vecs[3] = '{"no_cs_ignored",  1, 0, REG_PERIOD,  32'h77,       REG_PERIOD,  32'h12};
    vecs[4] = '{"push_len1",      1, 1, REG_PATTERN, 32'h5A,       REG_STATUS,  32'h0};
    vecs[5] = '{"cur_untouched",  0, 1, REG_CTRL,    32'h0,        REG_PATTERN, 32'h0};
    vecs[6] = '{"status_clear",   1, 1, REG_STATUS,  32'h0,        REG_STATUS,  32'h2};
    vecs[7] = '{"ctrl_upper",     1, 1, REG_CTRL,    32'hFFFFFFF8, REG_CTRL,    32'h0};
    vecs[8] = '{"ctrl_oneshot",   1, 1, REG_CTRL,    32'h4,        REG_CTRL,    32'h4};

    idle(3);
    @(negedge clk); reset = 1'b0;

    // Reset state
    check("rst m_chipselect", 32'(m_chipselect), 32'd0);
    check("rst m_write_n", 32'(m_write_n), 32'd1);
    check("rst m_writedata", m_writedata, 32'h0);
    check("rst done_irq", 32'(done_irq), 32'd0);
    reg_read(REG_CTRL, rd);    check("rst ctrl", rd, 32'h0);
    reg_read(REG_PERIOD, rd);  check("rst period", rd, 32'h0);
    reg_read(REG_PATTERN, rd); check("rst pattern", rd, 32'h0);
    reg_read(REG_STATUS, rd);  check("rst status", rd, 32'h2);

    // Register-file vectors
    foreach (vecs[i]) begin
      if (vecs[i].do_wr) bus_write(vecs[i].wa, vecs[i].wd, vecs[i].cs);
      reg_read(vecs[i].ra, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end
    check("vectors no master writes", 32'(wq.size()), 32'd0);

    // Table step, P=3
    pa = '{8'h01, 8'h02, 8'h04, 8'h00};
    run_seq(pa, 3, 3, 1'b0, 1'b0, 5, "step");

    // Rotate, P=0
    pa = '{8'h81, 8'h00, 8'h00, 8'h00};
    run_seq(pa, 1, 0, 1'b1, 1'b0, 4, "rotate");

    // One-shot, then STATUS write clears done
    pa = '{8'hAA, 8'h55, 8'h00, 8'h00};
    run_seq(pa, 2, 2, 1'b0, 1'b1, 0, "oneshot");
    bus_write(REG_STATUS, 32'h0);
    check("oneshot irq_cleared", 32'(done_irq), 32'd0);
    reg_read(REG_STATUS, rd); check("oneshot status_cleared", rd, 32'h2);

    // Fifth push dropped; clearing run during COUNT stops output
    bus_write(REG_CTRL, 32'h0);
    bus_write(REG_STATUS, 32'h0);
    for (int i = 0; i < 5; i++) bus_write(REG_PATTERN, 32'h10 + 32'(i));
    reg_read(REG_STATUS, rd); check("full status", rd, 32'h0);
    bus_write(REG_PERIOD, 32'd4);
    wq.delete();
    bus_write(REG_CTRL, 32'h1);
    wait_writes(5, 60, "full");
    if (wq.size() >= 5) begin
      check("full fourth", wq[3].data, 32'h13);
      check("full wrap_not_fifth", wq[4].data, 32'h10);
    end
    bus_write(REG_CTRL, 32'h0);
    idle(20);
    check("stop no_more_writes", 32'(wq.size()), 32'd5);
    reg_read(REG_STATUS, rd); check("stop status", rd, 32'h0);

    // Run with empty table in mode 0 never starts
    bus_write(REG_STATUS, 32'h0);
    wq.delete();
    bus_write(REG_CTRL, 32'h1);
    idle(20);
    check("empty no_writes", 32'(wq.size()), 32'd0);
    reg_read(REG_STATUS, rd); check("empty status", rd, 32'h2);
    bus_write(REG_CTRL, 32'h0);

    // Randomized runs against the reference
    for (int it = 0; it < 6; it++) begin
      int n, p, nwr;
      bit mode, os;
      n    = $urandom_range(1, 4);
      p    = $urandom_range(0, 5);
      nwr  = $urandom_range(3, 7);
      mode = 1'($urandom_range(0, 1));
      os   = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) pa[i] = 8'($urandom_range(0, 255));
      run_seq(pa, n, p, mode, os, nwr, $sformatf("rand%0d", it));
    end

    // Reset asserted during a WRITE cycle
    bus_write(REG_CTRL, 32'h0);
    bus_write(REG_STATUS, 32'h0);
    bus_write(REG_PATTERN, 32'hC3);
    bus_write(REG_PERIOD, 32'd5);
    bus_write(REG_CTRL, 32'h1);
    t = 0;
    while (m_chipselect !== 1'b1 && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    check("rstmid write_found", 32'(m_chipselect), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid m_write_n", 32'(m_write_n), 32'd1);
    check("rstmid m_chipselect", 32'(m_chipselect), 32'd0);
    check("rstmid m_writedata", m_writedata, 32'h0);
    @(negedge clk); reset = 1'b0;
    reg_read(REG_CTRL, rd);    check("rstmid ctrl", rd, 32'h0);
    reg_read(REG_PERIOD, rd);  check("rstmid period", rd, 32'h0);
    reg_read(REG_PATTERN, rd); check("rstmid pattern", rd, 32'h0);
    reg_read(REG_STATUS, rd);  check("rstmid status", rd, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
